// File: rtl/control_unit_pkg.sv
// Shared definitions for the Mini SRC hardwired control unit: opcodes,
// instruction classes, step encodings and the strobe bundle.
package cu_pkg;

    localparam int OPW   = 5;
    localparam int STEPW = 4;

    localparam logic [OPW-1:0] OP_LD   = 5'b00000;
    localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
    localparam logic [OPW-1:0] OP_ST   = 5'b00010;
    localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPW-1:0] OP_SHR  = 5'b00101;
    localparam logic [OPW-1:0] OP_SHRA = 5'b00110;
    localparam logic [OPW-1:0] OP_SHL  = 5'b00111;
    localparam logic [OPW-1:0] OP_ROR  = 5'b01000;
    localparam logic [OPW-1:0] OP_ROL  = 5'b01001;
    localparam logic [OPW-1:0] OP_AND  = 5'b01010;
    localparam logic [OPW-1:0] OP_OR   = 5'b01011;
    localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
    localparam logic [OPW-1:0] OP_ANDI = 5'b01101;
    localparam logic [OPW-1:0] OP_ORI  = 5'b01110;
    localparam logic [OPW-1:0] OP_MUL  = 5'b01111;
    localparam logic [OPW-1:0] OP_DIV  = 5'b10000;
    localparam logic [OPW-1:0] OP_NEG  = 5'b10001;
    localparam logic [OPW-1:0] OP_NOT  = 5'b10010;
    localparam logic [OPW-1:0] OP_BR   = 5'b10011;
    localparam logic [OPW-1:0] OP_JR   = 5'b10100;
    localparam logic [OPW-1:0] OP_JAL  = 5'b10101;
    localparam logic [OPW-1:0] OP_IN   = 5'b10110;
    localparam logic [OPW-1:0] OP_OUT  = 5'b10111;
    localparam logic [OPW-1:0] OP_MFHI = 5'b11000;
    localparam logic [OPW-1:0] OP_MFLO = 5'b11001;
    localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
    localparam logic [OPW-1:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        CL_ALU_R,
        CL_ALU_I,
        CL_UNARY,
        CL_MULDIV,
        CL_LD,
        CL_LDI,
        CL_ST,
        CL_BR,
        CL_JR,
        CL_JAL,
        CL_MFHI,
        CL_MFLO,
        CL_IN,
        CL_OUT,
        CL_NOP,
        CL_HALT
    } op_class_t;

    // T0..T7 are numerically ordered so execute steps advance by increment.
    typedef enum logic [STEPW-1:0] {
        ST_T0    = 4'd0,
        ST_T1    = 4'd1,
        ST_T2    = 4'd2,
        ST_T3    = 4'd3,
        ST_T4    = 4'd4,
        ST_T5    = 4'd5,
        ST_T6    = 4'd6,
        ST_T7    = 4'd7,
        ST_RESET = 4'd8,
        ST_HALT  = 4'd9
    } step_t;

    typedef struct packed {
        logic PCout;
        logic MDRout;
        logic RZHIout;
        logic RZLOout;
        logic HIout;
        logic LOout;
        logic Cout;
        logic InPortout;
        logic BAout;
        logic gra;
        logic grb;
        logic grc;
        logic rin;
        logic rout;
        logic PCin;
        logic IRin;
        logic MARin;
        logic MDRin;
        logic RYin;
        logic RZin;
        logic HIin;
        logic LOin;
        logic R15in;
        logic CONin;
        logic OUTPORTin;
        logic Read;
        logic Write;
        logic IncPC;
    } ctrl_t;

    function automatic step_t last_step(input op_class_t cls);
        step_t s;
        s = ST_T3;
        case (cls)
            CL_ALU_R, CL_ALU_I, CL_LDI: s = ST_T5;
            CL_UNARY, CL_JAL:           s = ST_T4;
            CL_MULDIV, CL_BR:           s = ST_T6;
            CL_LD, CL_ST:               s = ST_T7;
            default:                    s = ST_T3;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control-unit <-> DataPath connection: status inputs from the DataPath
// and every control strobe driven back into it.
interface control_unit_if;
    import cu_pkg::*;

    logic [31:0]    ir;
    logic           con_ff;
    logic           stop;
    logic           run;
    logic [OPW-1:0] ops;
    logic PCout, MDRout, RZHIout, RZLOout, HIout, LOout, Cout, InPortout, BAout;
    logic gra, grb, grc, rin, rout;
    logic PCin, IRin, MARin, MDRin, RYin, RZin, HIin, LOin, R15in, CONin, OUTPORTin;
    logic Read, Write, IncPC;

    modport master (
        input  ir, con_ff, stop,
        output run, ops,
        output PCout, MDRout, RZHIout, RZLOout, HIout, LOout, Cout, InPortout, BAout,
        output gra, grb, grc, rin, rout,
        output PCin, IRin, MARin, MDRin, RYin, RZin, HIin, LOin, R15in, CONin, OUTPORTin,
        output Read, Write, IncPC
    );

    modport slave (
        output ir, con_ff, stop,
        input  run, ops,
        input  PCout, MDRout, RZHIout, RZLOout, HIout, LOout, Cout, InPortout, BAout,
        input  gra, grb, grc, rin, rout,
        input  PCin, IRin, MARin, MDRin, RYin, RZin, HIin, LOin, R15in, CONin, OUTPORTin,
        input  Read, Write, IncPC
    );

endinterface

// File: rtl/control_unit_decode.sv
// Combinational opcode classifier; unlisted opcodes fall into the nop class.
module cu_decode
    import cu_pkg::*;
(
    input  logic [OPW-1:0] opcode,
    output op_class_t      cls
);

    always_comb begin
        cls = CL_NOP;
        case (opcode)
            OP_LD:   cls = CL_LD;
            OP_LDI:  cls = CL_LDI;
            OP_ST:   cls = CL_ST;
            OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL,
            OP_ROR, OP_ROL, OP_AND, OP_OR:
                     cls = CL_ALU_R;
            OP_ADDI, OP_ANDI, OP_ORI:
                     cls = CL_ALU_I;
            OP_MUL, OP_DIV:
                     cls = CL_MULDIV;
            OP_NEG, OP_NOT:
                     cls = CL_UNARY;
            OP_BR:   cls = CL_BR;
            OP_JR:   cls = CL_JR;
            OP_JAL:  cls = CL_JAL;
            OP_IN:   cls = CL_IN;
            OP_OUT:  cls = CL_OUT;
            OP_MFHI: cls = CL_MFHI;
            OP_MFLO: cls = CL_MFLO;
            OP_HALT: cls = CL_HALT;
            default: cls = CL_NOP;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired Mini SRC sequencer: fetch T0-T2, class-specific execute steps,
// then back to T0. Outputs are decoded from the step and the latched class.
module control_unit
    import cu_pkg::*;
(
    input  logic           clock,
    input  logic           clear,
    control_unit_if.master cu
);

    step_t          state;
    step_t          state_nxt;
    op_class_t      cls_q;
    op_class_t      cls_dec;
    logic [OPW-1:0] opc_q;
    ctrl_t          ctl;
    logic [OPW-1:0] ops;
    logic           run;

    cu_decode u_decode (
        .opcode (cu.ir[31:27]),
        .cls    (cls_dec)
    );

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state <= ST_RESET;
            cls_q <= CL_NOP;
            opc_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_T2) begin
                cls_q <= cls_dec;
                opc_q <= cu.ir[31:27];
            end
        end
    end

    // T2 branches on the live decode because the class register loads on that same edge.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RESET: state_nxt = ST_T0;
            ST_T0:    state_nxt = cu.stop ? ST_HALT : ST_T1;
            ST_T1:    state_nxt = ST_T2;
            ST_T2: begin
                case (cls_dec)
                    CL_NOP:  state_nxt = ST_T0;
                    CL_HALT: state_nxt = ST_HALT;
                    default: state_nxt = ST_T3;
                endcase
            end
            ST_HALT:  state_nxt = ST_HALT;
            default:  state_nxt = (state >= last_step(cls_q)) ? ST_T0
                                                               : step_t'(state + 4'd1);
        endcase
    end

    always_comb begin
        ctl = '0;
        ops = '0;
        run = 1'b0;
        case (state)
            ST_T0: begin
                run = 1'b1;
                ctl.PCout = 1'b1; ctl.MARin = 1'b1; ctl.IncPC = 1'b1; ctl.RZin = 1'b1;
            end
            ST_T1: begin
                run = 1'b1;
                ctl.RZLOout = 1'b1; ctl.PCin = 1'b1; ctl.Read = 1'b1; ctl.MDRin = 1'b1;
            end
            ST_T2: begin
                run = 1'b1;
                ctl.MDRout = 1'b1; ctl.IRin = 1'b1;
            end
            ST_T3, ST_T4, ST_T5, ST_T6, ST_T7: begin
                run = 1'b1;
                case (cls_q)
                    CL_ALU_R, CL_ALU_I: begin
                        case (state)
                            ST_T3: begin ctl.grb = 1'b1; ctl.rout = 1'b1; ctl.RYin = 1'b1; end
                            ST_T4: begin
                                ctl.RZin = 1'b1;
                                ops      = opc_q;
                                if (cls_q == CL_ALU_R) begin
                                    ctl.grc  = 1'b1;
                                    ctl.rout = 1'b1;
                                end else begin
                                    ctl.Cout = 1'b1;
                                end
                            end
                            ST_T5: begin ctl.RZLOout = 1'b1; ctl.gra = 1'b1; ctl.rin = 1'b1; end
                            default: ;
                        endcase
                    end
                    CL_UNARY: begin
                        case (state)
                            ST_T3: begin
                                ctl.grb = 1'b1; ctl.rout = 1'b1; ctl.RZin = 1'b1;
                                ops     = opc_q;
                            end
                            ST_T4: begin ctl.RZLOout = 1'b1; ctl.gra = 1'b1; ctl.rin = 1'b1; end
                            default: ;
                        endcase
                    end
                    CL_MULDIV: begin
                        case (state)
                            ST_T3: begin ctl.gra = 1'b1; ctl.rout = 1'b1; ctl.RYin = 1'b1; end
                            ST_T4: begin
                                ctl.grb = 1'b1; ctl.rout = 1'b1; ctl.RZin = 1'b1;
                                ops     = opc_q;
                            end
                            ST_T5: begin ctl.RZLOout = 1'b1; ctl.LOin = 1'b1; end
                            ST_T6: begin ctl.RZHIout = 1'b1; ctl.HIin = 1'b1; end
                            default: ;
                        endcase
                    end
                    // ld, ldi and st share the effective-address steps T3-T4.
                    CL_LD, CL_LDI, CL_ST: begin
                        case (state)
                            ST_T3: begin ctl.grb = 1'b1; ctl.BAout = 1'b1; ctl.RYin = 1'b1; end
                            ST_T4: begin ctl.Cout = 1'b1; ctl.RZin = 1'b1; ops = OP_ADD; end
                            ST_T5: begin
                                ctl.RZLOout = 1'b1;
                                if (cls_q == CL_LDI) begin
                                    ctl.gra = 1'b1;
                                    ctl.rin = 1'b1;
                                end else begin
                                    ctl.MARin = 1'b1;
                                end
                            end
                            ST_T6: begin
                                ctl.MDRin = 1'b1;
                                if (cls_q == CL_ST) begin
                                    ctl.gra  = 1'b1;
                                    ctl.rout = 1'b1;
                                end else begin
                                    ctl.Read = 1'b1;
                                end
                            end
                            ST_T7: begin
                                if (cls_q == CL_ST) begin
                                    ctl.Write = 1'b1;
                                end else begin
                                    ctl.MDRout = 1'b1; ctl.gra = 1'b1; ctl.rin = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                    CL_BR: begin
                        case (state)
                            ST_T3: begin ctl.gra = 1'b1; ctl.rout = 1'b1; ctl.CONin = 1'b1; end
                            ST_T4: begin ctl.PCout = 1'b1; ctl.RYin = 1'b1; end
                            ST_T5: begin ctl.Cout = 1'b1; ctl.RZin = 1'b1; ops = OP_ADD; end
                            ST_T6: begin ctl.RZLOout = 1'b1; ctl.PCin = cu.con_ff; end
                            default: ;
                        endcase
                    end
                    CL_JR: begin
                        if (state == ST_T3) begin
                            ctl.gra = 1'b1; ctl.rout = 1'b1; ctl.PCin = 1'b1;
                        end
                    end
                    CL_JAL: begin
                        case (state)
                            ST_T3: begin ctl.PCout = 1'b1; ctl.R15in = 1'b1; end
                            ST_T4: begin ctl.gra = 1'b1; ctl.rout = 1'b1; ctl.PCin = 1'b1; end
                            default: ;
                        endcase
                    end
                    CL_MFHI: if (state == ST_T3) begin ctl.gra = 1'b1; ctl.rin = 1'b1; ctl.HIout = 1'b1; end
                    CL_MFLO: if (state == ST_T3) begin ctl.gra = 1'b1; ctl.rin = 1'b1; ctl.LOout = 1'b1; end
                    CL_IN:   if (state == ST_T3) begin ctl.gra = 1'b1; ctl.rin = 1'b1; ctl.InPortout = 1'b1; end
                    CL_OUT:  if (state == ST_T3) begin ctl.gra = 1'b1; ctl.rout = 1'b1; ctl.OUTPORTin = 1'b1; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign cu.run       = run;
    assign cu.ops       = ops;
    assign cu.PCout     = ctl.PCout;
    assign cu.MDRout    = ctl.MDRout;
    assign cu.RZHIout   = ctl.RZHIout;
    assign cu.RZLOout   = ctl.RZLOout;
    assign cu.HIout     = ctl.HIout;
    assign cu.LOout     = ctl.LOout;
    assign cu.Cout      = ctl.Cout;
    assign cu.InPortout = ctl.InPortout;
    assign cu.BAout     = ctl.BAout;
    assign cu.gra       = ctl.gra;
    assign cu.grb       = ctl.grb;
    assign cu.grc       = ctl.grc;
    assign cu.rin       = ctl.rin;
    assign cu.rout      = ctl.rout;
    assign cu.PCin      = ctl.PCin;
    assign cu.IRin      = ctl.IRin;
    assign cu.MARin     = ctl.MARin;
    assign cu.MDRin     = ctl.MDRin;
    assign cu.RYin      = ctl.RYin;
    assign cu.RZin      = ctl.RZin;
    assign cu.HIin      = ctl.HIin;
    assign cu.LOin      = ctl.LOin;
    assign cu.R15in     = ctl.R15in;
    assign cu.CONin     = ctl.CONin;
    assign cu.OUTPORTin = ctl.OUTPORTin;
    assign cu.Read      = ctl.Read;
    assign cu.Write     = ctl.Write;
    assign cu.IncPC     = ctl.IncPC;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: each instruction's expected strobe sequence is
// built from a per-opcode table and compared state by state.
module tb_control_unit;

    localparam logic [27:0] M_PCOUT     = 28'd1 << 0;
    localparam logic [27:0] M_MDROUT    = 28'd1 << 1;
    localparam logic [27:0] M_RZHIOUT   = 28'd1 << 2;
    localparam logic [27:0] M_RZLOOUT   = 28'd1 << 3;
    localparam logic [27:0] M_HIOUT     = 28'd1 << 4;
    localparam logic [27:0] M_LOOUT     = 28'd1 << 5;
    localparam logic [27:0] M_COUT      = 28'd1 << 6;
    localparam logic [27:0] M_INPORTOUT = 28'd1 << 7;
    localparam logic [27:0] M_BAOUT     = 28'd1 << 8;
    localparam logic [27:0] M_GRA       = 28'd1 << 9;
    localparam logic [27:0] M_GRB       = 28'd1 << 10;
    localparam logic [27:0] M_GRC       = 28'd1 << 11;
    localparam logic [27:0] M_RIN       = 28'd1 << 12;
    localparam logic [27:0] M_ROUT      = 28'd1 << 13;
    localparam logic [27:0] M_PCIN      = 28'd1 << 14;
    localparam logic [27:0] M_IRIN      = 28'd1 << 15;
    localparam logic [27:0] M_MARIN     = 28'd1 << 16;
    localparam logic [27:0] M_MDRIN     = 28'd1 << 17;
    localparam logic [27:0] M_RYIN      = 28'd1 << 18;
    localparam logic [27:0] M_RZIN      = 28'd1 << 19;
    localparam logic [27:0] M_HIIN      = 28'd1 << 20;
    localparam logic [27:0] M_LOIN      = 28'd1 << 21;
    localparam logic [27:0] M_R15IN     = 28'd1 << 22;
    localparam logic [27:0] M_CONIN     = 28'd1 << 23;
    localparam logic [27:0] M_OUTPORTIN = 28'd1 << 24;
    localparam logic [27:0] M_READ      = 28'd1 << 25;
    localparam logic [27:0] M_WRITE     = 28'd1 << 26;
    localparam logic [27:0] M_INCPC     = 28'd1 << 27;
    localparam logic [4:0]  ALU_ADD     = 5'b00011;

    typedef struct packed {
        logic        run;
        logic [4:0]  ops;
        logic [27:0] mask;
    } exp_t;

    logic clock;
    logic clear;
    int   checks;
    int   failures;
    logic mon_en;
    logic hilo_seen;
    exp_t exp_q[$];

    control_unit_if bus ();

    control_unit dut (
        .clock (clock),
        .clear (clear),
        .cu    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [27:0] observedMask();
        return {bus.IncPC, bus.Write, bus.Read, bus.OUTPORTin, bus.CONin, bus.R15in,
                bus.LOin, bus.HIin, bus.RZin, bus.RYin, bus.MDRin, bus.MARin, bus.IRin,
                bus.PCin, bus.rout, bus.rin, bus.grc, bus.grb, bus.gra, bus.BAout,
                bus.InPortout, bus.Cout, bus.LOout, bus.HIout, bus.RZLOout, bus.RZHIout,
                bus.MDRout, bus.PCout};
    endfunction

    function automatic void addStep(input logic [27:0] m, input logic [4:0] o);
        exp_t e;
        e.run  = 1'b1;
        e.ops  = o;
        e.mask = m;
        exp_q.push_back(e);
    endfunction

    // Expected per-state strobes for one instruction, fetch through last execute step.
    function automatic void buildProgram(input logic [4:0] opc, input logic con);
        exp_q.delete();
        addStep(M_PCOUT | M_MARIN | M_INCPC | M_RZIN, 5'd0);
        addStep(M_RZLOOUT | M_PCIN | M_READ | M_MDRIN, 5'd0);
        addStep(M_MDROUT | M_IRIN, 5'd0);
        if (opc >= 5'd3 && opc <= 5'd11) begin
            addStep(M_GRB | M_ROUT | M_RYIN, 5'd0);
            addStep(M_GRC | M_ROUT | M_RZIN, opc);
            addStep(M_RZLOOUT | M_GRA | M_RIN, 5'd0);
        end else if (opc >= 5'd12 && opc <= 5'd14) begin
            addStep(M_GRB | M_ROUT | M_RYIN, 5'd0);
            addStep(M_COUT | M_RZIN, opc);
            addStep(M_RZLOOUT | M_GRA | M_RIN, 5'd0);
        end else if (opc == 5'd15 || opc == 5'd16) begin
            addStep(M_GRA | M_ROUT | M_RYIN, 5'd0);
            addStep(M_GRB | M_ROUT | M_RZIN, opc);
            addStep(M_RZLOOUT | M_LOIN, 5'd0);
            addStep(M_RZHIOUT | M_HIIN, 5'd0);
        end else if (opc == 5'd17 || opc == 5'd18) begin
            addStep(M_GRB | M_ROUT | M_RZIN, opc);
            addStep(M_RZLOOUT | M_GRA | M_RIN, 5'd0);
        end else if (opc <= 5'd2) begin
            addStep(M_GRB | M_BAOUT | M_RYIN, 5'd0);
            addStep(M_COUT | M_RZIN, ALU_ADD);
            if (opc == 5'd1) begin
                addStep(M_RZLOOUT | M_GRA | M_RIN, 5'd0);
            end else begin
                addStep(M_RZLOOUT | M_MARIN, 5'd0);
                if (opc == 5'd0) begin
                    addStep(M_READ | M_MDRIN, 5'd0);
                    addStep(M_MDROUT | M_GRA | M_RIN, 5'd0);
                end else begin
                    addStep(M_GRA | M_ROUT | M_MDRIN, 5'd0);
                    addStep(M_WRITE, 5'd0);
                end
            end
        end else if (opc == 5'd19) begin
            addStep(M_GRA | M_ROUT | M_CONIN, 5'd0);
            addStep(M_PCOUT | M_RYIN, 5'd0);
            addStep(M_COUT | M_RZIN, ALU_ADD);
            addStep(M_RZLOOUT | (con ? M_PCIN : 28'd0), 5'd0);
        end else if (opc == 5'd20) begin
            addStep(M_GRA | M_ROUT | M_PCIN, 5'd0);
        end else if (opc == 5'd21) begin
            addStep(M_PCOUT | M_R15IN, 5'd0);
            addStep(M_GRA | M_ROUT | M_PCIN, 5'd0);
        end else if (opc == 5'd22) begin
            addStep(M_GRA | M_RIN | M_INPORTOUT, 5'd0);
        end else if (opc == 5'd23) begin
            addStep(M_GRA | M_ROUT | M_OUTPORTIN, 5'd0);
        end else if (opc == 5'd24) begin
            addStep(M_GRA | M_RIN | M_HIOUT, 5'd0);
        end else if (opc == 5'd25) begin
            addStep(M_GRA | M_RIN | M_LOOUT, 5'd0);
        end
    endfunction

    task automatic applyStimulus(input logic [31:0] ir_v, input logic con_v, input logic stop_v);
        bus.ir     = ir_v;
        bus.con_ff = con_v;
        bus.stop   = stop_v;
    endtask

    task automatic checkOutput(input string tag, input exp_t e);
        exp_t o;
        o.run  = bus.run;
        o.ops  = bus.ops;
        o.mask = observedMask();
        checks++;
        assert (o === e) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic checkIdle(input string tag);
        exp_t z;
        z = '0;
        checkOutput(tag, z);
    endtask

    // Runs one instruction from T0 and leaves the bench one state past its last step.
    task automatic runProgram(input logic [31:0] ir_v, input logic con_v);
        buildProgram(ir_v[31:27], con_v);
        applyStimulus(ir_v, con_v, 1'b0);
        for (int i = 0; i < exp_q.size(); i++) begin
            checkOutput($sformatf("op%0d_s%0d", ir_v[31:27], i), exp_q[i]);
            step();
        end
    endtask

    task automatic clearPulse();
        clear = 1'b0;
        #1;
        checkIdle("clear_async");
        @(negedge clock);
        clear = 1'b1;
        step();
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            checks++;
            assert ($countones({bus.PCout, bus.MDRout, bus.RZHIout, bus.RZLOout, bus.HIout,
                                bus.LOout, bus.Cout, bus.InPortout, bus.BAout, bus.rout}) <= 1
                    && !(bus.Read && bus.Write) && !(bus.IncPC && bus.PCin)) else begin
                failures++;
                $error("[TB] FAIL exclusivity observed=%h expected=at most one driver",
                       observedMask());
            end
            if (bus.HIin || bus.LOin) hilo_seen = 1'b1;
        end
    end

    initial begin
        exp_t t0_exp;
        logic [4:0] opc;
        checks    = 0;
        failures  = 0;
        mon_en    = 1'b0;
        hilo_seen = 1'b0;
        clear     = 1'b0;
        applyStimulus(32'h0, 1'b0, 1'b0);
        buildProgram(5'd26, 1'b0);
        t0_exp = exp_q[0];

        repeat (2) @(posedge clock);
        @(negedge clock);
        mon_en = 1'b1;
        checkIdle("reset_state");
        clear = 1'b1;
        step();
        checkOutput("first_t0", t0_exp);

        $display("[TB] directed mflo, add, br");
        runProgram(32'hC8800000, 1'b0);
        runProgram(32'h19890000, 1'b0);
        checkOutput("add_back_to_t0", t0_exp);
        runProgram({5'd19, 27'h0123456}, 1'b0);
        runProgram({5'd19, 27'h0123456}, 1'b1);

        $display("[TB] every opcode once");
        for (int k = 0; k < 32; k++) begin
            if (k != 27) runProgram({5'(k), 27'(k * 7919)}, k[0]);
        end

        $display("[TB] random instruction stream");
        for (int k = 0; k < 40; k++) begin
            opc = 5'($urandom_range(0, 31));
            if (opc == 5'd27) opc = 5'd26;
            runProgram({opc, 27'($urandom)}, 1'($urandom_range(0, 1)));
        end
        checkOutput("random_end_t0", t0_exp);

        $display("[TB] mul aborted by clear in T4");
        hilo_seen = 1'b0;
        buildProgram(5'd15, 1'b0);
        applyStimulus({5'd15, 27'h0ABCDE}, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("mul_abort_s%0d", i), exp_q[i]);
            if (i < 4) step();
        end
        clearPulse();
        checkOutput("mul_recover_t0", t0_exp);
        checks++;
        assert (hilo_seen === 1'b0) else begin
            failures++;
            $error("[TB] FAIL mul_no_hilo observed=%b expected=0", hilo_seen);
        end

        $display("[TB] halt opcode");
        runProgram({5'd27, 27'h0}, 1'b0);
        for (int i = 0; i < 20; i++) checkIdle($sformatf("halt_op_c%0d", i));
        for (int i = 0; i < 20; i++) step();
        clearPulse();
        checkOutput("halt_recover_t0", t0_exp);

        $display("[TB] stop at T0");
        applyStimulus(32'h0, 1'b0, 1'b1);
        checkOutput("stop_t0", t0_exp);
        step();
        for (int i = 0; i < 20; i++) begin
            checkIdle($sformatf("stop_halt_c%0d", i));
            step();
        end
        applyStimulus(32'h0, 1'b0, 1'b0);
        clearPulse();
        checkOutput("stop_recover_t0", t0_exp);
        runProgram(32'hC8800000, 1'b0);
        checkOutput("final_t0", t0_exp);

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
